reg_writeback_sequencer: RTL

- Write-side companion to the 16x16 register file; sole driver of its write port (RegWrite, writeReg, writeData).
- Accepts writeback requests from the ALU path (one 16-bit result) and the multiply/divide path (32-bit result, split across two registers).
- Buffers requests in a small FIFO and retires them one register write per cycle, in order.
- Exports a pending-write mask so the decode stage can stall on RAW hazards.

---
 rtl/reg_writeback_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/reg_writeback_sequencer.sv
// reg_writeback_sequencer
// Sole driver of the 16x16 register file write port. Collects writeback
// requests from the ALU path (one 16-bit result) and the mul/div path
// (a 32-bit result split into two register writes). It queues them in a
// shift-register FIFO and retires one register write per cycle, in
// acceptance order.
//
// Ports:
//   clk, rst       clock (rising edge); synchronous active-high reset
//   alu_*          ALU writeback request (valid/ready, reg, data)
//   md_*           mul/div writeback request; lo goes to md_reg, hi to HI_REG
//   hold           stalls retirement while high
//   RegWrite, writeReg, writeData  registered register-file write port
//   pend_mask      one bit per register with a write still outstanding
//   count          FIFO occupancy (output stage excluded)
module reg_writeback_sequencer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned HI_REG = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [3:0]                 alu_reg,
    input  logic [15:0]                alu_data,
    input  logic                       md_valid,
    output logic                       md_ready,
    input  logic [3:0]                 md_reg,
    input  logic [15:0]                md_data_lo,
    input  logic [15:0]                md_data_hi,
    input  logic                       hold,
    output logic                       RegWrite,
    output logic [3:0]                 writeReg,
    output logic [15:0]                writeData,
    output logic [15:0]                pend_mask,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [3:0] HiReg = 4'(HI_REG);

    logic [3:0]    ent_reg_q  [DEPTH];
    logic [3:0]    ent_reg_d  [DEPTH];
    logic [15:0]   ent_data_q [DEPTH];
    logic [15:0]   ent_data_d [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] free;
    logic          md_push, alu_push, pop;
    logic          regwrite_q;
    logic [3:0]    write_reg_q;
    logic [15:0]   write_data_q;
    int unsigned   wr_base, alu_base;

    // Readiness depends only on the registered count, never on a same-cycle pop,
    // so upstream sees no combinational path through hold.
    always_comb begin
        free      = CW'(DEPTH) - count_q;
        md_ready  = (free >= CW'(2));
        md_push   = md_valid && md_ready;
        // An accepted md pair consumes two slots ahead of the ALU entry.
        alu_ready = (free >= (md_push ? CW'(3) : CW'(1)));
        alu_push  = alu_valid && alu_ready;
        pop       = !hold && (count_q != '0);
    end

    // Next FIFO contents: shift out the head on pop, then append the pushes
    // behind the surviving entries (md lo, md hi, alu).
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_reg_d[i]  = ent_reg_q[i];
            ent_data_d[i] = ent_data_q[i];
        end
        if (pop) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                ent_reg_d[i]  = ent_reg_q[i+1];
                ent_data_d[i] = ent_data_q[i+1];
            end
        end
        wr_base  = 32'(count_q) - 32'(pop);
        alu_base = wr_base + (md_push ? 32'd2 : 32'd0);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (md_push && i == wr_base) begin
                ent_reg_d[i]  = md_reg;
                ent_data_d[i] = md_data_lo;
            end
            if (md_push && i == wr_base + 1) begin
                ent_reg_d[i]  = HiReg;
                ent_data_d[i] = md_data_hi;
            end
            if (alu_push && i == alu_base) begin
                ent_reg_d[i]  = alu_reg;
                ent_data_d[i] = alu_data;
            end
        end
        count_d = count_q + (md_push ? CW'(2) : CW'(0)) + CW'(alu_push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            regwrite_q   <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_reg_q[i]  <= '0;
                ent_data_q[i] <= '0;
            end
        end else begin
            count_q    <= count_d;
            regwrite_q <= pop;
            if (pop) begin
                write_reg_q  <= ent_reg_q[0];
                write_data_q <= ent_data_q[0];
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_reg_q[i]  <= ent_reg_d[i];
                ent_data_q[i] <= ent_data_d[i];
            end
        end
    end

    // Only slots below count hold live entries; the output stage stays pending
    // until the cycle after its write commits.
    always_comb begin
        pend_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i < 32'(count_q)) begin
                pend_mask[ent_reg_q[i]] = 1'b1;
            end
        end
        if (regwrite_q) begin
            pend_mask[write_reg_q] = 1'b1;
        end
    end

    assign RegWrite  = regwrite_q;
    assign writeReg  = write_reg_q;
    assign writeData = write_data_q;
    assign count     = count_q;

endmodule
